// File: rtl/calc_arbiter_if.sv
// Request/response bundle between two requesters and calc_arbiter.
// master = requester side, slave = arbiter side.
`timescale 1ns/1ps
interface calc_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [3:0] rsp_r;
  logic       rsp_ovf;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r, rsp_ovf
  );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin scheduler time-sharing one combinational calculator between two requesters.
// Define CALC_ARB_STATS_EN to add the saturating overflow counter output ovf_count.
`timescale 1ns/1ps
module calc_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_arbiter_if.slave bus,
  output logic [2:0]    calc_op,
  output logic [3:0]    calc_a,
  output logic [3:0]    calc_b,
  input  logic [3:0]    calc_r,
  input  logic          calc_ovf,
  output logic          busy
`ifdef CALC_ARB_STATS_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] r_q, r_d;
  logic       ovf_q, ovf_d;
  logic       rdy0, rdy1;

  assign rdy0 = (state_q == IDLE) & bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign rdy1 = (state_q == IDLE) & bus.req1_valid & (~bus.req0_valid |  prio_q);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (rdy0) begin
          op_d    = bus.req0_op;
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          owner_d = 1'b0;
          prio_d  = 1'b1;
          cnt_d   = HOLD_INIT;
          state_d = ISSUE;
        end else if (rdy1) begin
          op_d    = bus.req1_op;
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          owner_d = 1'b1;
          prio_d  = 1'b0;
          cnt_d   = HOLD_INIT;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          r_d     = calc_r;
          ovf_d   = calc_ovf;
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
    end
  end

  // Response valids derive from state+owner, so a reset always drops them.
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = (state_q == RESP) & ~owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &  owner_q;
  assign bus.rsp_r      = r_q;
  assign bus.rsp_ovf    = ovf_q;
  assign calc_op        = op_q;
  assign calc_a         = a_q;
  assign calc_b         = b_q;
  assign busy           = (state_q != IDLE);

`ifdef CALC_ARB_STATS_EN
  logic [7:0] ovf_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else if ((state_q == ISSUE) && (cnt_q == '0) && calc_ovf && (ovf_count_q != '1)) begin
      ovf_count_q <= ovf_count_q + 8'd1;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: instance 0 uses HOLD_CYCLES=1, instance 1 uses HOLD_CYCLES=4.
// A transaction-level model is compared every cycle; directed checks pin literal results.
`timescale 1ns/1ps
module tb_calc_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] r0v, r1v, s0r, s1r, corrupt;
  logic [2:0] r0op[2], r1op[2];
  logic [3:0] r0a[2], r0b[2], r1a[2], r1b[2];
  logic [1:0] r0rdy, r1rdy, s0v, s1v, busyv, rovf, cov;
  logic [3:0] rr[2], ca[2], cb[2], crr[2];
  logic [2:0] cop[2];
`ifdef CALC_ARB_STATS_EN
  logic [7:0] ovfc[2];
`endif

  int nt = 0;
  int nf = 0;
  bit chk_en = 1'b0;

  // Reference calculator: {ovf, r}
  function automatic logic [4:0] calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    case (op)
      3'b000:  begin s = a + b; return {(a[3] == b[3]) && (s[3] != a[3]), s}; end
      3'b001:  begin s = a - b; return {(a[3] != b[3]) && (s[3] != a[3]), s}; end
      3'b010:  return {1'b0, a & b};
      3'b011:  begin s = b[3] ? (4'd0 - b) : b; return {b == 4'b1000, s}; end
      3'b100:  begin s = a + 4'd1; return {a == 4'd7, s}; end
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    calc_arbiter_if bus();

    calc_arbiter #(.HOLD_CYCLES(k == 0 ? 1 : 4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .calc_op  (cop[k]),
      .calc_a   (ca[k]),
      .calc_b   (cb[k]),
      .calc_r   (crr[k]),
      .calc_ovf (cov[k]),
      .busy     (busyv[k])
`ifdef CALC_ARB_STATS_EN
      ,
      .ovf_count(ovfc[k])
`endif
    );

    assign bus.req0_valid = r0v[k];
    assign bus.req0_op    = r0op[k];
    assign bus.req0_a     = r0a[k];
    assign bus.req0_b     = r0b[k];
    assign bus.req1_valid = r1v[k];
    assign bus.req1_op    = r1op[k];
    assign bus.req1_a     = r1a[k];
    assign bus.req1_b     = r1b[k];
    assign bus.rsp0_ready = s0r[k];
    assign bus.rsp1_ready = s1r[k];
    assign r0rdy[k] = bus.req0_ready;
    assign r1rdy[k] = bus.req1_ready;
    assign s0v[k]   = bus.rsp0_valid;
    assign s1v[k]   = bus.rsp1_valid;
    assign rr[k]    = bus.rsp_r;
    assign rovf[k]  = bus.rsp_ovf;
    // External calculator; corrupt inverts its output to prove early samples are not used.
    assign {cov[k], crr[k]} = calc(cop[k], ca[k], cb[k]) ^ (corrupt[k] ? 5'h1F : 5'h00);
  end

  // ---------------- transaction model ----------------
  logic [1:0] m_act, m_done, m_prio, m_own, m_ovf;
  logic [2:0] m_op[2];
  logic [3:0] m_a[2], m_b[2], m_r[2];
  int         m_el[2];
  int         m_cnt[2];

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic e_rdy0(input int k);
    return !m_act[k] && r0v[k] && (!r1v[k] || !m_prio[k]);
  endfunction

  function automatic logic e_rdy1(input int k);
    return !m_act[k] && r1v[k] && (!r0v[k] || m_prio[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_done[k] = 0; m_prio[k] = 0; m_own[k] = 0;
        m_op[k] = 0; m_a[k] = 0; m_b[k] = 0; m_r[k] = 0; m_ovf[k] = 0;
        m_el[k] = 0; m_cnt[k] = 0;
      end else if (!m_act[k]) begin
        if (e_rdy0(k) || e_rdy1(k)) begin
          m_own[k]  = !e_rdy0(k);
          m_prio[k] = !m_own[k];
          m_op[k]   = m_own[k] ? r1op[k] : r0op[k];
          m_a[k]    = m_own[k] ? r1a[k]  : r0a[k];
          m_b[k]    = m_own[k] ? r1b[k]  : r0b[k];
          m_act[k]  = 1;
          m_el[k]   = 0;
        end
      end else if (!m_done[k]) begin
        m_el[k]++;
        if (m_el[k] == hold_of(k)) begin
          m_done[k] = 1;
          {m_ovf[k], m_r[k]} = calc(m_op[k], m_a[k], m_b[k]);
          if (m_ovf[k] && m_cnt[k] < 255) m_cnt[k]++;
        end
      end else if (m_own[k] ? s1r[k] : s0r[k]) begin
        m_act[k]  = 0;
        m_done[k] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("k%0d_req0_ready", k), 8'(r0rdy[k]), 8'(e_rdy0(k)));
        chk($sformatf("k%0d_req1_ready", k), 8'(r1rdy[k]), 8'(e_rdy1(k)));
        chk($sformatf("k%0d_rsp0_valid", k), 8'(s0v[k]), 8'(m_act[k] && m_done[k] && !m_own[k]));
        chk($sformatf("k%0d_rsp1_valid", k), 8'(s1v[k]), 8'(m_act[k] && m_done[k] && m_own[k]));
        chk($sformatf("k%0d_busy", k), 8'(busyv[k]), 8'(m_act[k]));
        chk($sformatf("k%0d_rsp_r", k), 8'(rr[k]), 8'(m_r[k]));
        chk($sformatf("k%0d_rsp_ovf", k), 8'(rovf[k]), 8'(m_ovf[k]));
        chk($sformatf("k%0d_calc_op", k), 8'(cop[k]), 8'(m_op[k]));
        chk($sformatf("k%0d_calc_a", k), 8'(ca[k]), 8'(m_a[k]));
        chk($sformatf("k%0d_calc_b", k), 8'(cb[k]), 8'(m_b[k]));
`ifdef CALC_ARB_STATS_EN
        chk($sformatf("k%0d_ovf_count", k), ovfc[k], 8'(m_cnt[k]));
`endif
      end
    end
  end

  // Waits (bounded) for either response channel of instance k; ch=-1 on timeout.
  task automatic wait_rsp(input int k, output int ch);
    ch = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s0v[k]) begin ch = 0; break; end
      if (s1v[k]) begin ch = 1; break; end
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", nf);
    $fatal(1);
  end

  initial begin
    int ch;
    int n;
    r0v = '0; r1v = '0; s0r = '0; s1r = '0; corrupt = '0;
    for (int k = 0; k < 2; k++) begin
      r0op[k] = '0; r0a[k] = '0; r0b[k] = '0;
      r1op[k] = '0; r1a[k] = '0; r1b[k] = '0;
    end
    @(posedge clk);
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 8'(busyv[0]), 8'd0);
    chk("reset_rsp_r", 8'(rr[0]), 8'd0);
    chk("reset_calc_a", 8'(ca[1]), 8'd0);

    // single op, HOLD=1: 3+4
    step();
    r0v[0] = 1; r0op[0] = 3'b000; r0a[0] = 4'd3; r0b[0] = 4'd4; s0r[0] = 1;
    @(negedge clk);
    chk("t1_req0_ready_N", 8'(r0rdy[0]), 8'd1);
    step();
    r0v[0] = 0;
    @(negedge clk);
    chk("t1_calc_a_N1", 8'(ca[0]), 8'd3);
    chk("t1_rsp0_valid_N1", 8'(s0v[0]), 8'd0);
    step();
    @(negedge clk);
    chk("t1_rsp0_valid_N2", 8'(s0v[0]), 8'd1);
    chk("t1_rsp_r", 8'(rr[0]), 8'd7);
    chk("t1_rsp_ovf", 8'(rovf[0]), 8'd0);
    step();
    @(negedge clk);
    chk("t1_idle_N3", 8'(busyv[0]), 8'd0);

    // contention from reset: req0 5-2, req1 inc(7)
    step();
    rst_n = 0;
    r0v[0] = 1; r0op[0] = 3'b001; r0a[0] = 4'd5; r0b[0] = 4'd2;
    r1v[0] = 1; r1op[0] = 3'b100; r1a[0] = 4'd7; r1b[0] = 4'd1;
    s0r[0] = 1; s1r[0] = 1;
    step();
    rst_n = 1;
    wait_rsp(0, ch);
    chk("t2_first_grant", 8'(ch), 8'd0);
    chk("t2_first_r", 8'(rr[0]), 8'd3);
    wait_rsp(0, ch);
    chk("t2_second_grant", 8'(ch), 8'd1);
    chk("t2_second_r", 8'(rr[0]), 8'd8);
    chk("t2_second_ovf", 8'(rovf[0]), 8'd1);
    wait_rsp(0, ch);
    chk("t2_third_grant", 8'(ch), 8'd0);
    chk("t2_third_r", 8'(rr[0]), 8'd3);
    step();
    r0v[0] = 0; r1v[0] = 0;

    // backpressure on rsp1: C & A = 8
    step();
    r1v[0] = 1; r1op[0] = 3'b010; r1a[0] = 4'hC; r1b[0] = 4'hA; s1r[0] = 0;
    step();
    r1v[0] = 0;
    r0v[0] = 1; r0op[0] = 3'b000; r0a[0] = 4'd1; r0b[0] = 4'd1; s0r[0] = 1;
    wait_rsp(0, ch);
    chk("t3_grant", 8'(ch), 8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_r", 8'(rr[0]), 8'd8);
      chk("t3_hold_busy", 8'(busyv[0]), 8'd1);
      chk("t3_hold_req0_ready", 8'(r0rdy[0]), 8'd0);
    end
    step();
    s1r[0] = 1;
    @(negedge clk);
    chk("t3_rsp1_valid_last", 8'(s1v[0]), 8'd1);
    step();
    @(negedge clk);
    chk("t3_idle_after", 8'(busyv[0]), 8'd0);
    chk("t3_req0_ready_after", 8'(r0rdy[0]), 8'd1);
    step();
    r0v[0] = 0;
    repeat (4) step();

    // HOLD=4: abs(-8) with corrupted calculator during first three ISSUE cycles
    r0v[1] = 1; r0op[1] = 3'b011; r0a[1] = 4'd0; r0b[1] = 4'd8; s0r[1] = 1;
    @(negedge clk);
    chk("t4_req0_ready", 8'(r0rdy[1]), 8'd1);
    step();
    r0v[1] = 0; r0op[1] = 3'b000; r0a[1] = 4'd1; r0b[1] = 4'd1;
    corrupt[1] = 1;
    @(negedge clk);
    chk("t4_calc_b_held", 8'(cb[1]), 8'd8);
    step();
    step();
    step();
    corrupt[1] = 0;
    @(negedge clk);
    chk("t4_no_early_rsp", 8'(s0v[1]), 8'd0);
    chk("t4_calc_op_held", 8'(cop[1]), 8'd3);
    step();
    @(negedge clk);
    chk("t4_rsp0_valid", 8'(s0v[1]), 8'd1);
    chk("t4_rsp_r", 8'(rr[1]), 8'd8);
    chk("t4_rsp_ovf", 8'(rovf[1]), 8'd1);
    repeat (3) step();

    // reset during ISSUE, then prio back to req0 and a req1 grant
    r0v[0] = 1; r0op[0] = 3'b000; r0a[0] = 4'd1; r0b[0] = 4'd2; s0r[0] = 1; s1r[0] = 1;
    @(negedge clk);
    chk("t5_accept", 8'(r0rdy[0]), 8'd1);
    step();
    r0v[0] = 0;
    rst_n = 0;
    @(negedge clk);
    chk("t5_in_issue", 8'(busyv[0]), 8'd1);
    step();
    rst_n = 1;
    r0v[0] = 1; r0op[0] = 3'b000; r0a[0] = 4'd2; r0b[0] = 4'd2;
    r1v[0] = 1; r1op[0] = 3'b010; r1a[0] = 4'hF; r1b[0] = 4'd5;
    @(negedge clk);
    chk("t5_rsp0_dropped", 8'(s0v[0]), 8'd0);
    chk("t5_busy_cleared", 8'(busyv[0]), 8'd0);
    chk("t5_prio_req0", 8'(r0rdy[0]), 8'd1);
    chk("t5_prio_req1", 8'(r1rdy[0]), 8'd0);
    step();
    r0v[0] = 0;
    wait_rsp(0, ch);
    chk("t5_grant0", 8'(ch), 8'd0);
    chk("t5_r0", 8'(rr[0]), 8'd4);
    wait_rsp(0, ch);
    chk("t5_grant1", 8'(ch), 8'd1);
    chk("t5_r1", 8'(rr[0]), 8'd5);
    step();
    r1v[0] = 0;
    repeat (3) step();

`ifdef CALC_ARB_STATS_EN
    // 257 overflowing adds saturate the counter
    r0v[0] = 1; r0op[0] = 3'b000; r0a[0] = 4'd7; r0b[0] = 4'd1; s0r[0] = 1;
    n = 0;
    for (int i = 0; i < 3000 && n < 257; i++) begin
      @(negedge clk);
      if (s0v[0]) n++;
    end
    chk("t6_ops_done", 8'(n == 257), 8'd1);
    step();
    r0v[0] = 0;
    @(negedge clk);
    chk("t6_ovf_count_sat", ovfc[0], 8'd255);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("t6_ovf_count_reset", ovfc[0], 8'd0);
`else
    n = 0;
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
